// File: rtl/primitive_assembler_if.sv
// rtl/primitive_assembler_if.sv - component stream in, assembled-triangle stream out
// The master side feeds components and accepts triangles; the slave side is the assembler.
interface primitive_assembler_if #(
  parameter int M  = 11,
  parameter int XW = 10,
  parameter int YW = 9
);
  logic signed [M-1:0]     in_component;
  logic                    in_valid;
  logic                    flush;
  logic                    tri_valid;
  logic                    tri_ready;
  logic signed [M-1:0]     tri_x [3];
  logic signed [M-1:0]     tri_y [3];
  logic signed [M-1:0]     tri_z [3];
  logic signed [2*M+2:0]   tri_area;
  logic [XW-1:0]           bbox_xmin;
  logic [XW-1:0]           bbox_xmax;
  logic [YW-1:0]           bbox_ymin;
  logic [YW-1:0]           bbox_ymax;

  modport master (
    output in_component, in_valid, flush, tri_ready,
    input  tri_valid, tri_x, tri_y, tri_z, tri_area,
           bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax
  );

  modport slave (
    input  in_component, in_valid, flush, tri_ready,
    output tri_valid, tri_x, tri_y, tri_z, tri_area,
           bbox_xmin, bbox_xmax, bbox_ymin, bbox_ymax
  );
endinterface

// File: rtl/primitive_assembler.sv
// rtl/primitive_assembler.sv - triangle assembly, 3-stage setup, cull and output FIFO
// Survivors are queued show-ahead; the FIFO head drives the triangle outputs directly.
module primitive_assembler #(
  parameter int M          = 11,
  parameter int SCREEN_W   = 640,
  parameter int SCREEN_H   = 480,
  parameter int FIFO_DEPTH = 4,
  parameter int CULL_BACK  = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  primitive_assembler_if.slave bus,
  output logic                overflow,
  output logic [15:0]         cull_count
);
  localparam int XW = $clog2(SCREEN_W);
  localparam int YW = $clog2(SCREEN_H);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int AR = 2*M + 3;
  localparam logic signed [M+1:0] X_LIM = (M+2)'(SCREEN_W - 1);
  localparam logic signed [M+1:0] Y_LIM = (M+2)'(SCREEN_H - 1);

  typedef struct packed {
    logic [2:0][M-1:0] x;
    logic [2:0][M-1:0] y;
    logic [2:0][M-1:0] z;
    logic [AR-1:0]     area;
    logic [XW-1:0]     xmin;
    logic [XW-1:0]     xmax;
    logic [YW-1:0]     ymin;
    logic [YW-1:0]     ymax;
  } tri_t;

  function automatic logic signed [M-1:0] min3(input logic signed [M-1:0] a, b, c);
    logic signed [M-1:0] m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic logic signed [M-1:0] max3(input logic signed [M-1:0] a, b, c);
    logic signed [M-1:0] m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

  function automatic logic [M+1:0] clamp(input logic signed [M+1:0] v, input logic signed [M+1:0] lim);
    return v[M+1] ? '0 : ((v > lim) ? lim : v);
  endfunction

  logic [1:0]          comp_cnt, vert_cnt;
  logic signed [M-1:0] vx [3], vy [3], vz [3];
  logic                e0_valid;

  // w is counted but never stored; the edge taking vertex 2's w launches setup.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      comp_cnt <= '0;
      vert_cnt <= '0;
      e0_valid <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        vx[i] <= '0;
        vy[i] <= '0;
        vz[i] <= '0;
      end
    end else begin
      e0_valid <= 1'b0;
      if (bus.flush) begin
        comp_cnt <= '0;
        vert_cnt <= '0;
      end else if (bus.in_valid) begin
        comp_cnt <= comp_cnt + 2'd1;
        case (comp_cnt)
          2'd0: vx[vert_cnt] <= bus.in_component;
          2'd1: vy[vert_cnt] <= bus.in_component;
          2'd2: vz[vert_cnt] <= bus.in_component;
          default: begin
            vert_cnt <= (vert_cnt == 2'd2) ? 2'd0 : vert_cnt + 2'd1;
            e0_valid <= (vert_cnt == 2'd2);
          end
        endcase
      end
    end
  end

  logic                s1_valid;
  logic signed [M:0]   s1_dx1, s1_dy1, s1_dx2, s1_dy2;
  logic signed [M-1:0] s1_xmin, s1_xmax, s1_ymin, s1_ymax;
  logic signed [M-1:0] s1_x [3], s1_y [3], s1_z [3];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_dx1 <= '0; s1_dy1 <= '0; s1_dx2 <= '0; s1_dy2 <= '0;
      s1_xmin <= '0; s1_xmax <= '0; s1_ymin <= '0; s1_ymax <= '0;
      for (int i = 0; i < 3; i++) begin
        s1_x[i] <= '0;
        s1_y[i] <= '0;
        s1_z[i] <= '0;
      end
    end else begin
      s1_valid <= e0_valid;
      if (e0_valid) begin
        s1_dx1  <= (M+1)'(vx[1]) - (M+1)'(vx[0]);
        s1_dy1  <= (M+1)'(vy[1]) - (M+1)'(vy[0]);
        s1_dx2  <= (M+1)'(vx[2]) - (M+1)'(vx[0]);
        s1_dy2  <= (M+1)'(vy[2]) - (M+1)'(vy[0]);
        s1_xmin <= min3(vx[0], vx[1], vx[2]);
        s1_xmax <= max3(vx[0], vx[1], vx[2]);
        s1_ymin <= min3(vy[0], vy[1], vy[2]);
        s1_ymax <= max3(vy[0], vy[1], vy[2]);
        for (int i = 0; i < 3; i++) begin
          s1_x[i] <= vx[i];
          s1_y[i] <= vy[i];
          s1_z[i] <= vz[i];
        end
      end
    end
  end

  logic signed [AR-1:0]  prod1, prod2, area;
  logic signed [M+1:0]   xmin_e, xmax_e, ymin_e, ymax_e;
  logic [M+1:0]          cx_min, cx_max, cy_min, cy_max;
  logic                  cull;
  tri_t                  s2_d;

  always_comb begin
    prod1  = AR'(s1_dx1) * AR'(s1_dy2);
    prod2  = AR'(s1_dx2) * AR'(s1_dy1);
    area   = prod1 - prod2;
    xmin_e = (M+2)'(s1_xmin);
    xmax_e = (M+2)'(s1_xmax);
    ymin_e = (M+2)'(s1_ymin);
    ymax_e = (M+2)'(s1_ymax);
    cx_min = clamp(xmin_e, X_LIM);
    cx_max = clamp(xmax_e, X_LIM);
    cy_min = clamp(ymin_e, Y_LIM);
    cy_max = clamp(ymax_e, Y_LIM);
    cull   = (area == '0) || ((CULL_BACK != 0) && area[AR-1]) ||
             xmax_e[M+1] || (xmin_e > X_LIM) || ymax_e[M+1] || (ymin_e > Y_LIM);
    s2_d   = '0;
    for (int i = 0; i < 3; i++) begin
      s2_d.x[i] = s1_x[i];
      s2_d.y[i] = s1_y[i];
      s2_d.z[i] = s1_z[i];
    end
    s2_d.area = area;
    s2_d.xmin = cx_min[XW-1:0];
    s2_d.xmax = cx_max[XW-1:0];
    s2_d.ymin = cy_min[YW-1:0];
    s2_d.ymax = cy_max[YW-1:0];
  end

  logic s2_valid, s2_keep;
  tri_t s2_entry;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s2_valid <= 1'b0;
      s2_keep  <= 1'b0;
      s2_entry <= '0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_keep  <= !cull;
        s2_entry <= s2_d;
      end
    end
  end

  tri_t         mem [FIFO_DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr, count;
  logic         full, pop, push_req, push;
  tri_t         head;

  assign count    = wr_ptr - rd_ptr;
  assign full     = (count == (AW+1)'(FIFO_DEPTH));
  assign pop      = bus.tri_valid && bus.tri_ready;
  assign push_req = s2_valid && s2_keep;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign push     = push_req && (!full || pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      overflow   <= 1'b0;
      cull_count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= s2_entry;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push_req && !push) overflow <= 1'b1;
      if (s2_valid && !s2_keep && cull_count != 16'hFFFF) cull_count <= cull_count + 16'd1;
    end
  end

  assign head          = mem[rd_ptr[AW-1:0]];
  assign bus.tri_valid = (wr_ptr != rd_ptr);
  assign bus.tri_area  = head.area;
  assign bus.bbox_xmin = head.xmin;
  assign bus.bbox_xmax = head.xmax;
  assign bus.bbox_ymin = head.ymin;
  assign bus.bbox_ymax = head.ymax;

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      bus.tri_x[i] = head.x[i];
      bus.tri_y[i] = head.y[i];
      bus.tri_z[i] = head.z[i];
    end
  end
endmodule

// File: tb/tb_primitive_assembler.sv
// tb/tb_primitive_assembler.sv - directed bench for primitive_assembler
// A second instance with CULL_BACK=0 shares the input stream and is always ready.
module tb_primitive_assembler;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset_n;
  logic signed [10:0] in_comp;
  logic               in_valid, flush, tri_ready;
  logic               overflow, ov_nc;
  logic [15:0]        cull_count, cc_nc;
  int                 n_checks = 0;
  int                 n_fail   = 0;

  primitive_assembler_if #(.M(11), .XW(10), .YW(9)) bus ();
  primitive_assembler_if #(.M(11), .XW(10), .YW(9)) bus_nc ();

  assign bus.in_component    = in_comp;
  assign bus.in_valid        = in_valid;
  assign bus.flush           = flush;
  assign bus.tri_ready       = tri_ready;
  assign bus_nc.in_component = in_comp;
  assign bus_nc.in_valid     = in_valid;
  assign bus_nc.flush        = flush;
  assign bus_nc.tri_ready    = 1'b1;

  primitive_assembler #(.M(11), .SCREEN_W(640), .SCREEN_H(480), .FIFO_DEPTH(4), .CULL_BACK(1)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus), .overflow(overflow), .cull_count(cull_count));

  primitive_assembler #(.M(11), .SCREEN_W(640), .SCREEN_H(480), .FIFO_DEPTH(4), .CULL_BACK(0)) dut_nc (
    .clk(clk), .reset_n(reset_n), .bus(bus_nc), .overflow(ov_nc), .cull_count(cc_nc));

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  // Returns just after the edge that takes vertex 2's w; random junk sits on idle gaps.
  task automatic send_tri(input int x0, y0, z0, x1, y1, z1, x2, y2, z2, input int gap_max);
    int c [12];
    c = '{x0, y0, z0, 7, x1, y1, z1, 7, x2, y2, z2, 7};
    for (int i = 0; i < 12; i++) begin
      if (gap_max > 0) begin
        repeat ($urandom_range(gap_max, 0)) begin
          in_valid = 1'b0;
          in_comp  = 11'($urandom);
          idle();
        end
      end
      in_valid = 1'b1;
      in_comp  = 11'(c[i]);
      idle();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in_valid = 1'b0; flush = 1'b0; tri_ready = 1'b1; in_comp = '0;
    repeat (2) idle();
    n_checks++; if (bus.tri_valid !== 1'b0) begin n_fail++; $display("FAIL reset_tri_valid: got %b expected 0", bus.tri_valid); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    n_checks++; if (cull_count !== 16'd0) begin n_fail++; $display("FAIL reset_cull_count: got %0d expected 0", cull_count); end
    n_checks++; if (bus.tri_area !== 25'sd0 || bus.bbox_xmax !== 10'd0 || bus.tri_x[1] !== 11'sd0)
      begin n_fail++; $display("FAIL reset_data: area %0d xmax %0d x1 %0d expected all 0", bus.tri_area, bus.bbox_xmax, bus.tri_x[1]); end
    reset_n = 1'b1;
    idle();
  endtask

  task automatic test_ccw();
    send_tri(0, 0, 1, 10, 0, 2, 0, 10, 3, 0);
    idle(); idle();
    n_checks++; if (bus.tri_valid !== 1'b0) begin n_fail++; $display("FAIL ccw_early_valid: got %b expected 0 at E2", bus.tri_valid); end
    idle();
    n_checks++; if (bus.tri_valid !== 1'b1) begin n_fail++; $display("FAIL ccw_latency: got %b expected 1 at E3", bus.tri_valid); end
    n_checks++; if (bus.tri_area !== 25'sd100) begin n_fail++; $display("FAIL ccw_area: got %0d expected 100", bus.tri_area); end
    n_checks++; if (bus.bbox_xmin !== 10'd0 || bus.bbox_xmax !== 10'd10 || bus.bbox_ymin !== 9'd0 || bus.bbox_ymax !== 9'd10)
      begin n_fail++; $display("FAIL ccw_bbox: got (%0d,%0d)-(%0d,%0d) expected (0,0)-(10,10)", bus.bbox_xmin, bus.bbox_ymin, bus.bbox_xmax, bus.bbox_ymax); end
    n_checks++; if (bus.tri_x[0] !== 11'sd0 || bus.tri_x[1] !== 11'sd10 || bus.tri_x[2] !== 11'sd0)
      begin n_fail++; $display("FAIL ccw_tri_x: got {%0d,%0d,%0d} expected {0,10,0}", bus.tri_x[0], bus.tri_x[1], bus.tri_x[2]); end
    n_checks++; if (bus.tri_y[2] !== 11'sd10 || bus.tri_z[0] !== 11'sd1 || bus.tri_z[2] !== 11'sd3)
      begin n_fail++; $display("FAIL ccw_yz: got y2 %0d z0 %0d z2 %0d expected 10 1 3", bus.tri_y[2], bus.tri_z[0], bus.tri_z[2]); end
    idle();
    n_checks++; if (bus.tri_valid !== 1'b0) begin n_fail++; $display("FAIL ccw_pop: got %b expected 0 after handshake", bus.tri_valid); end
  endtask

  task automatic test_cw_cull();
    send_tri(0, 0, 0, 0, 10, 0, 10, 0, 0, 0);
    idle(); idle(); idle();
    n_checks++; if (bus.tri_valid !== 1'b0) begin n_fail++; $display("FAIL cw_culled: got tri_valid %b expected 0", bus.tri_valid); end
    n_checks++; if (cull_count !== 16'd1) begin n_fail++; $display("FAIL cw_cull_count: got %0d expected 1", cull_count); end
    n_checks++; if (bus_nc.tri_valid !== 1'b1) begin n_fail++; $display("FAIL cw_nocull_valid: got %b expected 1", bus_nc.tri_valid); end
    n_checks++; if (bus_nc.tri_area !== -25'sd100) begin n_fail++; $display("FAIL cw_nocull_area: got %0d expected -100", bus_nc.tri_area); end
    idle();
  endtask

  task automatic test_offscreen();
    send_tri(-50, -50, 0, -10, -50, 0, -50, -10, 0, 0);
    idle(); idle(); idle();
    n_checks++; if (bus.tri_valid !== 1'b0 || cull_count !== 16'd2)
      begin n_fail++; $display("FAIL offscreen_drop: got valid %b cull %0d expected 0 2", bus.tri_valid, cull_count); end
    n_checks++; if (cc_nc !== 16'd1) begin n_fail++; $display("FAIL offscreen_nocull_count: got %0d expected 1", cc_nc); end
    idle();
    send_tri(-5, -5, 0, 700, 0, 0, 0, 500, 0, 0);
    idle(); idle(); idle();
    n_checks++; if (bus.tri_valid !== 1'b1 || bus.tri_area !== 25'sd356000)
      begin n_fail++; $display("FAIL clamp_area: got valid %b area %0d expected 1 356000", bus.tri_valid, bus.tri_area); end
    n_checks++; if (bus.bbox_xmin !== 10'd0 || bus.bbox_xmax !== 10'd639 || bus.bbox_ymin !== 9'd0 || bus.bbox_ymax !== 9'd479)
      begin n_fail++; $display("FAIL clamp_bbox: got (%0d,%0d)-(%0d,%0d) expected (0,0)-(639,479)", bus.bbox_xmin, bus.bbox_ymin, bus.bbox_xmax, bus.bbox_ymax); end
    idle();
  endtask

  task automatic test_fifo_full();
    tri_ready = 1'b0;
    for (int k = 1; k <= 5; k++) send_tri(0, 0, k, 10, 0, k, 0, 10, k, 0);
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL fifo_no_early_overflow: got %b expected 0", overflow); end
    idle(); idle(); idle();
    n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL fifo_overflow: got %b expected 1", overflow); end
    tri_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      n_checks++; if (bus.tri_valid !== 1'b1 || bus.tri_z[0] !== 11'(k))
        begin n_fail++; $display("FAIL fifo_order: got valid %b z %0d expected 1 %0d", bus.tri_valid, bus.tri_z[0], k); end
      idle();
    end
    n_checks++; if (bus.tri_valid !== 1'b0) begin n_fail++; $display("FAIL fifo_drained: got %b expected 0", bus.tri_valid); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 6; i++) begin in_valid = 1'b1; in_comp = 11'sd99; idle(); end
    flush = 1'b1; in_comp = 11'sd77; idle();
    flush = 1'b0; in_valid = 1'b0;
    send_tri(0, 0, 4, 10, 0, 5, 0, 10, 6, 0);
    idle(); idle(); idle();
    n_checks++; if (bus.tri_valid !== 1'b1 || bus.tri_area !== 25'sd100)
      begin n_fail++; $display("FAIL flush_realign: got valid %b area %0d expected 1 100", bus.tri_valid, bus.tri_area); end
    n_checks++; if (bus.tri_x[1] !== 11'sd10 || bus.tri_y[2] !== 11'sd10 || bus.tri_z[0] !== 11'sd4)
      begin n_fail++; $display("FAIL flush_vertices: got x1 %0d y2 %0d z0 %0d expected 10 10 4", bus.tri_x[1], bus.tri_y[2], bus.tri_z[0]); end
    idle();
  endtask

  task automatic test_async_reset_gaps();
    tri_ready = 1'b0;
    send_tri(0, 0, 1, 10, 0, 2, 0, 10, 3, 0);
    idle(); idle(); idle();
    n_checks++; if (bus.tri_valid !== 1'b1) begin n_fail++; $display("FAIL pre_reset_queued: got %b expected 1", bus.tri_valid); end
    in_valid = 1'b1; in_comp = 11'sd33; idle(); idle();
    in_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    n_checks++; if (bus.tri_valid !== 1'b0 || overflow !== 1'b0 || cull_count !== 16'd0)
      begin n_fail++; $display("FAIL async_reset: got valid %b ovf %b cull %0d expected 0 0 0", bus.tri_valid, overflow, cull_count); end
    idle();
    reset_n = 1'b1; tri_ready = 1'b1;
    idle();
    send_tri(-5, -5, 0, 700, 0, 0, 0, 500, 0, 3);
    idle(); idle();
    n_checks++; if (bus.tri_valid !== 1'b0) begin n_fail++; $display("FAIL gaps_early_valid: got %b expected 0 at E2", bus.tri_valid); end
    idle();
    n_checks++; if (bus.tri_valid !== 1'b1 || bus.tri_area !== 25'sd356000 || bus.bbox_xmax !== 10'd639 || bus.bbox_ymax !== 9'd479)
      begin n_fail++; $display("FAIL gaps_result: got valid %b area %0d xmax %0d ymax %0d expected 1 356000 639 479",
                               bus.tri_valid, bus.tri_area, bus.bbox_xmax, bus.bbox_ymax); end
    idle();
  endtask

  initial begin
    test_reset();
    test_ccw();
    test_cw_cull();
    test_offscreen();
    test_fifo_full();
    test_flush();
    test_async_reset_gaps();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
